// File: rtl/mvb_frame_scheduler.sv
// mvb_frame_scheduler: arbitrates master/slave frame requests, loads the MVB encoder
// FIFO word by word on the 3 MHz word tick, fires send_frame and waits for frame_over.
// Optional statistics counters are built when MVB_SCHED_STATS_EN is defined.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | no frame in progress, waiting for an enabled request
// ST_LOAD   | presenting words to the encoder FIFO on word ticks
// ST_FIRE   | enc_send_frame held high for SEND_PULSE cycles
// ST_WAIT   | waiting for frame_over rising edge or timeout
// ST_GAP    | enforced idle gap before the next grant
module mvb_frame_scheduler #(
    parameter int SEND_PULSE     = 32,
    parameter int GAP_CYCLES     = 48,
    parameter int TIMEOUT_CYCLES = 16384
) (
    input  logic        clk_24M,
    input  logic        rst,
    input  logic        enable,
    input  logic        word_tick,
    input  logic        m_req,
    input  logic [15:0] m_data,
    output logic        m_ack,
    input  logic        s_req,
    input  logic [2:0]  s_size,
    output logic        s_rd_en,
    output logic [3:0]  s_rd_addr,
    input  logic [15:0] s_rd_data,
    output logic        s_ack,
    output logic [15:0] enc_data,
    output logic        enc_wr_en,
    output logic [6:0]  enc_frame_length,
    output logic        enc_M_frame,
    output logic        enc_S_frame,
    output logic        enc_send_frame,
    input  logic        enc_frame_over,
    output logic        busy,
    output logic        timeout_err,
    output logic        size_err
`ifdef MVB_SCHED_STATS_EN
    ,
    output logic [15:0] m_count,
    output logic [15:0] s_count,
    output logic [7:0]  err_count
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FIRE,
        ST_WAIT,
        ST_GAP
    } state_t;

    state_t      state;
    logic [15:0] cnt;
    logic        last_grant_m;
    logic        is_master;
    logic [4:0]  n_words;
    logic [4:0]  tick_idx;
    logic [15:0] m_word;
    logic [15:0] pref;
    logic        pref_ok;
    logic        rd_vld;
    logic        fo_q;

    logic        grant_m;
    logic        grant_s;
    logic [15:0] load_word;
    logic        word_ready;
    logic        fo_rise;

    // Round-robin arbitration; no grant while an ack is visible so the requester can drop
    always_comb begin
        grant_m = 1'b0;
        grant_s = 1'b0;
        if (enable && !m_ack && !s_ack) begin
            if (m_req && s_req) begin
                grant_m = !last_grant_m;
                grant_s = last_grant_m;
            end else begin
                grant_m = m_req;
                grant_s = s_req;
            end
        end
    end

    // Slave words bypass the prefetch register when they arrive in the tick cycle
    assign load_word  = is_master ? m_word : (rd_vld ? s_rd_data : pref);
    assign word_ready = is_master || pref_ok || rd_vld || (tick_idx == n_words);
    assign fo_rise    = enc_frame_over && !fo_q;

    // Frame sequencing FSM with registered encoder and requester outputs
    always_ff @(posedge clk_24M) begin
        if (!rst) begin
            state            <= ST_IDLE;
            cnt              <= '0;
            last_grant_m     <= 1'b0;
            is_master        <= 1'b0;
            n_words          <= '0;
            tick_idx         <= '0;
            m_word           <= '0;
            pref             <= '0;
            pref_ok          <= 1'b0;
            rd_vld           <= 1'b0;
            fo_q             <= 1'b0;
            m_ack            <= 1'b0;
            s_ack            <= 1'b0;
            s_rd_en          <= 1'b0;
            s_rd_addr        <= '0;
            enc_data         <= '0;
            enc_wr_en        <= 1'b0;
            enc_frame_length <= '0;
            enc_M_frame      <= 1'b0;
            enc_S_frame      <= 1'b0;
            enc_send_frame   <= 1'b0;
            busy             <= 1'b0;
            timeout_err      <= 1'b0;
            size_err         <= 1'b0;
`ifdef MVB_SCHED_STATS_EN
            m_count          <= '0;
            s_count          <= '0;
            err_count        <= '0;
`endif
        end else begin
            m_ack   <= 1'b0;
            s_ack   <= 1'b0;
            s_rd_en <= 1'b0;
            fo_q    <= enc_frame_over;
            rd_vld  <= s_rd_en;
            if (rd_vld) begin
                pref    <= s_rd_data;
                pref_ok <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (grant_m) begin
                        state            <= ST_LOAD;
                        busy             <= 1'b1;
                        is_master        <= 1'b1;
                        last_grant_m     <= 1'b1;
                        m_word           <= m_data;
                        enc_M_frame      <= 1'b1;
                        enc_S_frame      <= 1'b0;
                        n_words          <= 5'd1;
                        enc_frame_length <= 7'd1;
                        tick_idx         <= '0;
                        pref_ok          <= 1'b0;
                    end else if (grant_s) begin
                        last_grant_m <= 1'b0;
                        if (s_size > 3'd4) begin
                            s_ack    <= 1'b1;
                            size_err <= 1'b1;
`ifdef MVB_SCHED_STATS_EN
                            if (err_count != '1) err_count <= err_count + 8'd1;
`endif
                        end else begin
                            state            <= ST_LOAD;
                            busy             <= 1'b1;
                            is_master        <= 1'b0;
                            enc_S_frame      <= 1'b1;
                            enc_M_frame      <= 1'b0;
                            n_words          <= 5'd1 << s_size;
                            enc_frame_length <= 7'd1 << s_size;
                            tick_idx         <= '0;
                            pref_ok          <= 1'b0;
                            s_rd_en          <= 1'b1;
                            s_rd_addr        <= '0;
                        end
                    end
                end

                ST_LOAD: begin
                    if (word_tick && word_ready) begin
                        if (tick_idx == n_words) begin
                            enc_wr_en      <= 1'b0;
                            enc_send_frame <= 1'b1;
                            cnt            <= 16'(SEND_PULSE - 1);
                            state          <= ST_FIRE;
                        end else begin
                            enc_data  <= load_word;
                            enc_wr_en <= 1'b1;
                            tick_idx  <= tick_idx + 5'd1;
                            pref_ok   <= 1'b0;
                            if (!is_master && ((tick_idx + 5'd1) < n_words)) begin
                                s_rd_en   <= 1'b1;
                                s_rd_addr <= tick_idx[3:0] + 4'd1;
                            end
                        end
                    end
                end

                ST_FIRE: begin
                    if (cnt == '0) begin
                        enc_send_frame <= 1'b0;
                        cnt            <= 16'(TIMEOUT_CYCLES - 1);
                        state          <= ST_WAIT;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end

                ST_WAIT: begin
                    // A frame_over edge coinciding with expiry wins over the timeout
                    if (fo_rise || cnt == '0) begin
                        if (is_master) m_ack <= 1'b1;
                        else           s_ack <= 1'b1;
                        cnt   <= 16'(GAP_CYCLES - 1);
                        state <= ST_GAP;
                        if (!fo_rise) begin
                            timeout_err <= 1'b1;
`ifdef MVB_SCHED_STATS_EN
                            if (err_count != '1) err_count <= err_count + 8'd1;
`endif
                        end
`ifdef MVB_SCHED_STATS_EN
                        else if (is_master) begin
                            if (m_count != '1) m_count <= m_count + 16'd1;
                        end else begin
                            if (s_count != '1) s_count <= s_count + 16'd1;
                        end
`endif
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end

                ST_GAP: begin
                    if (cnt == '0) begin
                        busy             <= 1'b0;
                        enc_M_frame      <= 1'b0;
                        enc_S_frame      <= 1'b0;
                        enc_frame_length <= '0;
                        state            <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
